// File: rtl/ama_riscv_dmem.sv
// Data-memory responder: word-organised RAM with byte-lane stores, load shaping, sticky access-error flag.
// Latency: stores commit at the request edge; load data and rvalid appear one cycle after the request edge.
// Backpressure: none; one request per cycle is always accepted, loads may issue back-to-back.
//
// Optional build macro: DMEM_MMIO_EN adds a tohost register (0xFFFF_0000) and a
// read-only free-running cycle counter (0xFFFF_0004), decoded ahead of the range check.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   en_i, we_i             request strobe, byte-lane write mask (zero = load)
//   addr_i, wdata_i        byte address, lane-aligned store data
//   load_sm_en_i, funct3_i load shaping enable and load width/sign code
//   rdata_o, rvalid_o      shaped load data and its one-cycle valid pulse
//   err_o, err_addr_o      sticky access-error flag and address of the first error
//   tohost_o               tohost register (DMEM_MMIO_EN builds only)

module ama_riscv_dmem #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned AW          = 12
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic [3:0]  we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        load_sm_en_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] rdata_o,
  output logic        rvalid_o,
  output logic        err_o,
  output logic [31:0] err_addr_o
`ifdef DMEM_MMIO_EN
  ,
  output logic [31:0] tohost_o
`endif
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Source of the word presented in the read stage.
  localparam logic [1:0] SRC_ZERO = 2'd0;
  localparam logic [1:0] SRC_RAM  = 2'd1;
  localparam logic [1:0] SRC_MMIO = 2'd2;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [AW-1:0] idx;
  logic          is_store;
  logic          is_load;
  logic          addr_in_range;
  logic          mmio_hit;
  logic          mmio_err;
  logic          oor;
  logic          misaligned;
  logic          err_set;

  assign idx           = addr_i[AW+1:2];
  assign is_store      = en_i && (we_i != 4'b0000);
  assign is_load       = en_i && (we_i == 4'b0000);
  assign addr_in_range = (addr_i[31:AW+2] == '0);

`ifdef DMEM_MMIO_EN
  logic        is_tohost;
  logic        is_cycle;
  logic [31:0] tohost_q;
  logic [31:0] cycle_q;
  logic [31:0] mmio_rd_q;

  assign is_tohost = (addr_i == 32'hFFFF_0000);
  assign is_cycle  = (addr_i == 32'hFFFF_0004);
  assign mmio_hit  = is_tohost || is_cycle;
  // Only a full-word store to tohost is legal; the counter is read-only.
  assign mmio_err  = is_store && ((is_tohost && (we_i != 4'b1111)) || is_cycle);
`else
  assign mmio_hit  = 1'b0;
  assign mmio_err  = 1'b0;
`endif

  assign oor = en_i && !mmio_hit && !addr_in_range;

  // Misaligned accesses are flagged but still performed with the truncated offset.
  always_comb begin
    misaligned = 1'b0;
    if (is_load) begin
      if (((funct3_i == F3_LH) || (funct3_i == F3_LHU)) && addr_i[0])
        misaligned = 1'b1;
      if ((funct3_i == F3_LW) && (addr_i[1:0] != 2'b00))
        misaligned = 1'b1;
    end else if (is_store) begin
      if (((we_i == 4'b0011) || (we_i == 4'b1100)) && addr_i[0])
        misaligned = 1'b1;
      if ((we_i == 4'b1111) && (addr_i[1:0] != 2'b00))
        misaligned = 1'b1;
    end
  end

  assign err_set = oor || misaligned || mmio_err;

  // ---------------------------------------------------------------------------
  // RAM array: not reset, kept in reset-free processes so it maps onto block RAM
  // ---------------------------------------------------------------------------
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] ram_rd_q;
  logic        ram_we;
  logic        ram_re;

  assign ram_we = is_store && !mmio_hit && addr_in_range;
  assign ram_re = is_load  && !mmio_hit && addr_in_range;

  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (we_i[i]) mem[idx][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (ram_re) ram_rd_q <= mem[idx];
  end

  // ---------------------------------------------------------------------------
  // Read-stage control and sticky error
  // ---------------------------------------------------------------------------
  logic       rvalid_q;
  logic [1:0] src_q;
  logic [1:0] src_d;
  logic [1:0] off_q;
  logic [2:0] f3_q;
  logic       sm_q;
  logic       err_q;
  logic [31:0] err_addr_q;

  always_comb begin
    src_d = SRC_ZERO;
    if (mmio_hit)           src_d = SRC_MMIO;
    else if (addr_in_range) src_d = SRC_RAM;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      src_q    <= SRC_ZERO;
      off_q    <= 2'b00;
      f3_q     <= 3'b000;
      sm_q     <= 1'b0;
    end else begin
      rvalid_q <= is_load;
      if (is_load) begin
        src_q <= src_d;
        off_q <= addr_i[1:0];
        f3_q  <= funct3_i;
        sm_q  <= load_sm_en_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q      <= 1'b0;
      err_addr_q <= 32'h0;
    end else if (err_set) begin
      err_q <= 1'b1;
      if (!err_q) err_addr_q <= addr_i;
    end
  end

`ifdef DMEM_MMIO_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tohost_q  <= 32'h0;
      cycle_q   <= 32'h0;
      mmio_rd_q <= 32'h0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (is_store && is_tohost && (we_i == 4'b1111)) tohost_q <= wdata_i;
      // The counter value returned is the one present at the request edge.
      if (is_load && is_tohost) mmio_rd_q <= tohost_q;
      if (is_load && is_cycle)  mmio_rd_q <= cycle_q;
    end
  end

  assign tohost_o = tohost_q;
`endif

  // ---------------------------------------------------------------------------
  // Load shaping
  // ---------------------------------------------------------------------------
  logic [31:0] raw_word;
  logic [31:0] shifted;
  logic [15:0] half;
  logic [31:0] shaped;

  always_comb begin
    raw_word = 32'h0;
    case (src_q)
      SRC_RAM:  raw_word = ram_rd_q;
`ifdef DMEM_MMIO_EN
      SRC_MMIO: raw_word = mmio_rd_q;
`endif
      default:  raw_word = 32'h0;
    endcase
  end

  assign shifted = raw_word >> {off_q, 3'b000};
  assign half    = off_q[1] ? raw_word[31:16] : raw_word[15:0];

  always_comb begin
    shaped = raw_word;
    if (sm_q) begin
      case (f3_q)
        F3_LB:   shaped = {{24{shifted[7]}}, shifted[7:0]};
        F3_LBU:  shaped = {24'h0, shifted[7:0]};
        F3_LH:   shaped = {{16{half[15]}}, half};
        F3_LHU:  shaped = {16'h0, half};
        F3_LW:   shaped = raw_word;
        default: shaped = raw_word;   // reserved codes pass the raw word
      endcase
    end
  end

  // src_q/off_q/f3_q/sm_q only move on loads, so rdata holds between responses.
  assign rdata_o    = shaped;
  assign rvalid_o   = rvalid_q;
  assign err_o      = err_q;
  assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_ama_riscv_dmem.sv
module tb_ama_riscv_dmem;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        sm;
  logic [2:0]  f3;
  logic [31:0] rdata;
  logic        rvalid;
  logic        err;
  logic [31:0] err_addr;
`ifdef DMEM_MMIO_EN
  logic [31:0] tohost;
`endif

  int n_chk = 0;
  int n_err = 0;

  ama_riscv_dmem #(.DEPTH_WORDS(4096), .AW(12)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (en),
    .we_i         (we),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .load_sm_en_i (sm),
    .funct3_i     (f3),
    .rdata_o      (rdata),
    .rvalid_o     (rvalid),
    .err_o        (err),
    .err_addr_o   (err_addr)
`ifdef DMEM_MMIO_EN
    ,
    .tohost_o     (tohost)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        sm;
    logic [2:0]  f3;
    logic        exp_rv;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic e, input logic [3:0] w, input logic [31:0] a,
                     input logic [31:0] d, input logic s, input logic [2:0] f,
                     input logic erv, input logic [31:0] erd);
    vec_t v;
    v.en = e; v.we = w; v.addr = a; v.wdata = d; v.sm = s; v.f3 = f;
    v.exp_rv = erv; v.exp_rd = erd;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic e, input logic [3:0] w, input logic [31:0] a,
                       input logic [31:0] d, input logic s, input logic [2:0] f);
    en = e; we = w; addr = a; wdata = d; sm = s; f3 = f;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 3'b010);
  endtask

  // Advance through one rising edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [31:0] c1;
  logic [31:0] c2;

  initial begin
    rst_n = 1'b0;
    idle();

    // Vector table: {en, we, addr, wdata, sm, f3, exp_rvalid, exp_rdata}
    add(1, 4'hF, 32'h10, 32'hDEADBEEF, 1, 3'b010, 0, 32'h0);
    add(1, 4'h0, 32'h10, 32'h0,        1, 3'b010, 1, 32'hDEADBEEF);
    add(1, 4'hF, 32'h20, 32'h11223344, 1, 3'b010, 0, 32'hDEADBEEF);
    add(1, 4'h1, 32'h20, 32'h00008000, 1, 3'b010, 0, 32'hDEADBEEF);
    add(1, 4'h0, 32'h20, 32'h0,        1, 3'b010, 1, 32'h11223300);
    add(1, 4'h2, 32'h20, 32'h0000AB00, 1, 3'b010, 0, 32'h11223300);
    add(1, 4'h0, 32'h21, 32'h0,        1, 3'b000, 1, 32'hFFFFFFAB);
    add(1, 4'h0, 32'h21, 32'h0,        1, 3'b100, 1, 32'h000000AB);
    add(1, 4'hF, 32'h30, 32'h80017FFF, 1, 3'b010, 0, 32'h000000AB);
    add(1, 4'h0, 32'h30, 32'h0,        1, 3'b001, 1, 32'h00007FFF);
    add(1, 4'h0, 32'h32, 32'h0,        1, 3'b001, 1, 32'hFFFF8001);
    add(1, 4'h0, 32'h32, 32'h0,        1, 3'b101, 1, 32'h00008001);
    add(1, 4'h0, 32'h32, 32'h0,        0, 3'b001, 1, 32'h80017FFF);
    add(1, 4'hF, 32'h40, 32'hCAFEF00D, 1, 3'b010, 0, 32'h80017FFF);
    add(1, 4'h0, 32'h40, 32'h0,        1, 3'b010, 1, 32'hCAFEF00D);
    add(0, 4'h0, 32'h40, 32'h0,        1, 3'b010, 0, 32'hCAFEF00D);
    add(1, 4'h0, 32'h30, 32'h0,        1, 3'b011, 1, 32'h80017FFF);
    add(1, 4'h0, 32'h13, 32'h0,        1, 3'b000, 1, 32'hFFFFFFDE);
    add(1, 4'h0, 32'h10, 32'h0,        1, 3'b100, 1, 32'h000000EF);
    add(0, 4'hF, 32'h10, 32'h0,        1, 3'b010, 0, 32'h000000EF);
    add(1, 4'h0, 32'h10, 32'h0,        1, 3'b010, 1, 32'hDEADBEEF);

    // Reset values
    #3;
    chk("reset_rdata",    rdata,    32'h0);
    chk("reset_rvalid",   {31'h0, rvalid}, 32'h0);
    chk("reset_err",      {31'h0, err},    32'h0);
    chk("reset_err_addr", err_addr, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].sm, vecs[i].f3);
      step();
      chk($sformatf("vec%0d_rvalid", i), {31'h0, rvalid}, {31'h0, vecs[i].exp_rv});
      chk($sformatf("vec%0d_rdata", i),  rdata, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i),    {31'h0, err}, 32'h0);
    end

    // Out-of-range load, then error address stays with the first error
    drive(1, 4'h0, 32'h4000, 32'h0, 1, 3'b010);
    step();
    chk("oor_rvalid",   {31'h0, rvalid}, 32'h1);
    chk("oor_rdata",    rdata, 32'h0);
    chk("oor_err",      {31'h0, err}, 32'h1);
    chk("oor_err_addr", err_addr, 32'h4000);
    drive(1, 4'h0, 32'h2, 32'h0, 1, 3'b010);
    step();
    chk("mis2_rvalid",   {31'h0, rvalid}, 32'h1);
    chk("mis2_err_addr", err_addr, 32'h4000);
    drive(1, 4'hF, 32'h4010, 32'h12345678, 1, 3'b010);
    step();
    chk("oor_st_rvalid",   {31'h0, rvalid}, 32'h0);
    chk("oor_st_err_addr", err_addr, 32'h4000);
    drive(1, 4'h0, 32'h10, 32'h0, 1, 3'b010);
    step();
    chk("oor_st_dropped", rdata, 32'hDEADBEEF);

    // Reset asserted with a response on the outputs
    drive(1, 4'h0, 32'h40, 32'h0, 1, 3'b010);
    step();
    chk("pre_rst_rvalid", {31'h0, rvalid}, 32'h1);
    chk("pre_rst_rdata",  rdata, 32'hCAFEF00D);
    idle();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid",   {31'h0, rvalid}, 32'h0);
    chk("mid_rst_err",      {31'h0, err}, 32'h0);
    chk("mid_rst_err_addr", err_addr, 32'h0);
    chk("mid_rst_rdata",    rdata, 32'h0);
    step();
    rst_n = 1'b1;

    // Load request whose edge falls inside reset produces no response
    drive(1, 4'h0, 32'h40, 32'h0, 1, 3'b010);
    #2;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle();
    step();
    chk("rst_drop_rvalid", {31'h0, rvalid}, 32'h0);
    drive(1, 4'h0, 32'h40, 32'h0, 1, 3'b010);
    step();
    chk("ram_kept_rvalid", {31'h0, rvalid}, 32'h1);
    chk("ram_kept_rdata",  rdata, 32'hCAFEF00D);

    // Misaligned accesses are flagged and still performed
    drive(1, 4'hF, 32'h41, 32'h01020304, 1, 3'b010);
    step();
    chk("mis_st_err",      {31'h0, err}, 32'h1);
    chk("mis_st_err_addr", err_addr, 32'h41);
    drive(1, 4'h0, 32'h40, 32'h0, 1, 3'b010);
    step();
    chk("mis_st_done", rdata, 32'h01020304);
    drive(1, 4'h0, 32'h31, 32'h0, 1, 3'b001);
    step();
    chk("mis_lh_rdata",    rdata, 32'h00007FFF);
    chk("mis_lh_err_addr", err_addr, 32'h41);

    // MMIO window
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
`ifdef DMEM_MMIO_EN
    drive(1, 4'hF, 32'hFFFF_0000, 32'h1, 1, 3'b010);
    step();
    chk("tohost_wr",  tohost, 32'h1);
    chk("tohost_err", {31'h0, err}, 32'h0);
    drive(1, 4'h0, 32'hFFFF_0000, 32'h0, 1, 3'b010);
    step();
    chk("tohost_rd", rdata, 32'h1);
    drive(1, 4'h0, 32'hFFFF_0004, 32'h0, 1, 3'b010);
    step();
    c1 = rdata;
    idle();
    repeat (4) step();
    drive(1, 4'h0, 32'hFFFF_0004, 32'h0, 1, 3'b010);
    step();
    c2 = rdata;
    chk("cycle_delta", c2 - c1, 32'd5);
    chk("cycle_err",   {31'h0, err}, 32'h0);
    drive(1, 4'h1, 32'hFFFF_0000, 32'hFF, 1, 3'b010);
    step();
    chk("tohost_partial_keep",     tohost, 32'h1);
    chk("tohost_partial_err",      {31'h0, err}, 32'h1);
    chk("tohost_partial_err_addr", err_addr, 32'hFFFF_0000);
`else
    drive(1, 4'h0, 32'hFFFF_0004, 32'h0, 1, 3'b010);
    step();
    c1 = rdata;
    chk("nommio_rvalid",   {31'h0, rvalid}, 32'h1);
    chk("nommio_rdata",    c1, 32'h0);
    chk("nommio_err",      {31'h0, err}, 32'h1);
    chk("nommio_err_addr", err_addr, 32'hFFFF_0004);
`endif

    idle();
    step();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ama_riscv_dmem.md
Name: ama_riscv_dmem

Overview:
- Data-memory responder: the receiving end of the core's dmem request interface (dmem_en, byte-lane write mask dmem_we, load shaping enable).
- Holds a word-organised synchronous RAM with per-byte writes and a 1-cycle registered read.
- Performs load alignment and sign or zero extension in its read stage.
- Flags out-of-range and misaligned accesses; sits between the MEM stage and the writeback mux.

Parameters:
- DEPTH_WORDS, 4096, number of 32-bit words; must be a power of 2.
- AW, 12, word-address width = log2(DEPTH_WORDS).

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  access request this cycle (dmem_en).
- we  input  4  byte-lane write mask; lane i = wdata[8i+7:8i]. Nonzero = store, zero = load.
- addr  input  32  byte address from the ALU.
- wdata  input  32  store data, already lane-aligned by the core.
- load_sm_en  input  1  apply load shaping; 0 returns the raw word.
- funct3  input  3  load width/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- rdata  output  32  shaped load data, valid when rvalid.
- rvalid  output  1  one-cycle pulse, the cycle after a load is accepted.
- err  output  1  sticky access-error flag.
- err_addr  output  32  byte address of the first erroring access.
- tohost  output  32  present only with DMEM_MMIO_EN.

Behaviour:
- Reset (rst=0, async): rdata=0, rvalid=0, err=0, err_addr=0, tohost=0. The RAM array is not reset and is untouched by reset. Reset mid-load drops the pending response (no rvalid after release).
- Word index = addr[AW+1:2]. An address is in range iff addr[31:AW+2]==0.
- Store: en=1, we!=0, in range. Lanes with we[i]=1 are written at the rising edge; other lanes keep their value. rvalid stays 0; rdata holds.
- Load: en=1, we=0, in range. RAM read at edge N. Capture addr[1:0] and funct3 in the same edge.
- Load response at N+1: rvalid=1, rdata shaped:
  - LB/LBU: byte at offset addr[1:0], sign- or zero-extended.
  - LH/LHU: half at addr[1], sign- or zero-extended.
  - LW: full word.
  - load_sm_en=0: raw word, no shaping.
- Reserved funct3 codes (011, 110, 111) with load_sm_en=1 return the raw word and set no error.
- Pipelining: back-to-back loads give one rvalid per cycle. A store at cycle N followed by a load of the same word at N+1 returns the new data; no bypass is needed because the array is already updated.
- en=0: no access, rvalid=0, rdata holds its last value.
- Out of range:
  - Store is dropped.
  - Load returns rdata=0 with rvalid=1 at N+1.
  - err set at the edge; err_addr captured only if err was 0.
- Misaligned access sets err and err_addr the same way, and is still performed:
  - LH/LHU, or a store with we in {0011, 1100} but addr[0]=1.
  - LW, or we=1111, with addr[1:0]!=0.
  - A misaligned load returns the half or word selected by the truncated offset.
- err clears only on reset.

Optional Feature:
- Macro: DMEM_MMIO_EN.
- When defined, two word-aligned addresses are decoded ahead of the range check and never touch the RAM:
  - 0xFFFF_0000: tohost register. A store with we=1111 updates tohost. A partial store is ignored and sets err. A load returns tohost.
  - 0xFFFF_0004: read-only 32-bit free-running cycle counter. Resets to 0, +1 every cycle, wraps 0xFFFF_FFFF to 0. A load returns the value sampled at the request edge. A store is ignored and sets err.
- When undefined: no tohost port, no counter. These addresses are ordinary out-of-range accesses.

Test Plan:
- Reset, then store 0xDEADBEEF to addr 0x10 with we=1111; LW 0x10 -> rdata=0xDEADBEEF, rvalid=1 exactly one cycle later.
- Store 0x0000_8000 with we=0001 to 0x20 (word previously 0x11223344); LW -> 0x11223300. Store lane 1 we=0010 with wdata=0x0000AB00; then LB 0x21 -> 0xFFFFFFAB, LBU 0x21 -> 0x000000AB.
- Word 0x30 = 0x8001_7FFF: LH 0x30 -> 0x00007FFF, LH 0x32 -> 0xFFFF8001, LHU 0x32 -> 0x00008001, load_sm_en=0 -> 0x80017FFF.
- Store at N then LW same addr at N+1 -> new data. Three consecutive loads -> rvalid high three consecutive cycles. en=0 -> rvalid=0, rdata holds.
- Out-of-range:
  - LW 0x0000_4000 (DEPTH_WORDS=4096) -> rdata=0, err=1, err_addr=0x4000.
  - Then LW 0x2 -> err_addr stays 0x4000.
  - Assert rst=0 mid-load -> rvalid=0, err=0 immediately; RAM contents preserved.
- DMEM_MMIO_EN:
  - Store 0x1 to 0xFFFF_0000 -> tohost=0x1.
  - Two LW of 0xFFFF_0004 issued 5 cycles apart -> values differ by 5.
  - Without the macro, LW 0xFFFF_0004 -> err=1.
